// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// This block sits between the CPU memory stage and the word-organised data RAM.
// The RAM has a combinational read, a synchronous write and no byte enables.
// Byte and half-word stores are done as read-modify-write. Loads come back
// sign- or zero-extended, together with a one-cycle response pulse.
// The byte-lane logic assumes DATA_W == 32.

module ram_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // An access is rejected if the size code is illegal, or if the address is
  // not aligned to the natural boundary of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lo[0];
      SIZE_W:  bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Writes the right-aligned store data into the selected lane of the old word.
  function automatic logic [DATA_W-1:0] merge_lane(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_data,
    input logic [1:0]        size,
    input logic [1:0]        lane
  );
    logic [DATA_W-1:0] w;
    w = old_word;
    case (size)
      SIZE_B: begin
        case (lane)
          2'b00:   w[7:0]   = new_data[7:0];
          2'b01:   w[15:8]  = new_data[7:0];
          2'b10:   w[23:16] = new_data[7:0];
          2'b11:   w[31:24] = new_data[7:0];
          default: w        = old_word;
        endcase
      end
      SIZE_H: begin
        if (lane[1]) begin
          w[31:16] = new_data[15:0];
        end else begin
          w[15:0]  = new_data[15:0];
        end
      end
      default: w = new_data;
    endcase
    return w;
  endfunction

  // Picks the addressed lane out of a RAM word and extends it to full width.
  function automatic logic [DATA_W-1:0] extract_lane(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        size,
    input logic [1:0]        lane,
    input logic              uns
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    if (lane[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      SIZE_B:  r = {{(DATA_W-8){b[7] & ~uns}}, b};
      SIZE_H:  r = {{(DATA_W-16){h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_e            state_r;
  state_e            state_next_s;

  // Request fields latched on acceptance
  logic              we_r;
  logic [1:0]        size_r;
  logic              unsigned_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;

  // Registered outputs
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;
  logic              ram_we_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_wdata_r;

  logic              ready_s;
  logic              accept_s;
  logic              req_err_s;
  logic [ADDR_W-1:0] aligned_addr_s;
  logic [DATA_W-1:0] merged_s;
  logic [DATA_W-1:0] load_data_s;

  // Ready is taken straight from state, and reset masks it.
  assign ready_s     = (state_r == IDLE) && !rst_i;
  assign accept_s    = req_valid_i && ready_s;
  assign req_err_s   = is_misaligned(req_size_i, req_addr_i[1:0]);
  assign merged_s    = merge_lane(ram_rdata_i, wdata_r, size_r, addr_r[1:0]);
  assign load_data_s = extract_lane(ram_rdata_i, size_r, addr_r[1:0], unsigned_r);

  // On the accept edge, the latched address is not available yet, so the
  // address is taken from the request.
  always_comb begin
    aligned_addr_s = '0;
    if (state_r == IDLE) begin
      aligned_addr_s = {req_addr_i[ADDR_W-1:2], 2'b00};
    end else begin
      aligned_addr_s = {addr_r[ADDR_W-1:2], 2'b00};
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. Errors go straight to RESP. Word stores skip the read.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_err_s) begin
            state_next_s = RESP;
          end else if (req_we_i && (req_size_i == SIZE_W)) begin
            state_next_s = WR;
          end else begin
            state_next_s = RD;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RD: begin
        if (we_r) begin
          state_next_s = WR;
        end else begin
          state_next_s = RESP;
        end
      end
      WR:      state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Latch every request field on acceptance. Inputs are ignored outside IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_r       <= 1'b0;
      size_r     <= 2'b00;
      unsigned_r <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
    end else if (accept_s) begin
      we_r       <= req_we_i;
      size_r     <= req_size_i;
      unsigned_r <= req_unsigned_i;
      addr_r     <= req_addr_i;
      wdata_r    <= req_wdata_i;
    end
  end

  // RAM-side outputs are decoded from the next state, so they are aligned
  // with the state they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ram_we_r    <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
    end else begin
      ram_we_r <= (state_next_s == WR);
      if ((state_next_s == RD) || (state_next_s == WR)) begin
        ram_addr_r <= aligned_addr_s;
      end else begin
        ram_addr_r <= '0;
      end
      if ((state_r == IDLE) && (state_next_s == WR)) begin
        ram_wdata_r <= req_wdata_i;
      end else if ((state_r == RD) && (state_next_s == WR)) begin
        ram_wdata_r <= merged_s;
      end
    end
  end

  // Response registers. Data and error change only when entering RESP, and
  // hold their value otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= (state_next_s == RESP);
      if (state_next_s == RESP) begin
        case (state_r)
          IDLE: begin
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b1;
          end
          RD: begin
            rsp_rdata_r <= load_data_s;
            rsp_err_r   <= 1'b0;
          end
          default: begin
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req_ready_o = ready_s;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;
  assign ram_we_o    = ram_we_r;
  assign ram_addr_o  = ram_addr_r;
  assign ram_wdata_o = ram_wdata_r;

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Initiator-side controller for the word-organised data RAM.
  - The RAM has a combinational read, a synchronous write, no byte enables, and is indexed by addr bits [RAM_ADDR_WIDTH+1:2].
- Accepts byte, half-word and word load/store requests from the CPU memory stage over a valid/ready handshake.
- Performs read-modify-write for sub-word stores.
- Returns loads sign- or zero-extended with a one-cycle response pulse.

Parameters:
- ADDR_W, 32, request/RAM address width.
- DATA_W, 32, data width. Byte-lane logic is defined only for 32.

Ports:
- clk_i  in  1  clock; all state changes on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  controller can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  load zero-extend when 1, sign-extend when 0.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned or illegal size; valid with rsp_valid_o.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM byte address; bits [1:0] forced to 00.
- ram_wdata_o  out  DATA_W  RAM write word.
- ram_rdata_i  in  DATA_W  RAM combinational read data.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, all latched request fields 0.
  - An in-flight access is dropped with no response. A write in WR is aborted: ram_we_o falls before any post-reset edge.
- req_ready_o = (state==IDLE) && !rst_i. It is combinational from state.
- Accept on posedge with req_valid_i && req_ready_o. All request fields are latched on acceptance. Inputs are ignored outside IDLE.
- States are IDLE, RD, WR, RESP.
- Acceptance is at edge N. Misalignment check:
  - Error if size 11, or half with addr[0]=1, or word with addr[1:0]!=00.
  - An error goes to RESP with err=1. No RAM access. rsp_valid_o is high in cycle N+1.
- Load:
  - Cycle N+1 in RD: ram_addr_o = {addr[ADDR_W-1:2],2'b00}, ram_we_o=0.
  - At the end of N+1, the extracted and extended data is registered.
  - Cycle N+2 in RESP: rsp_valid_o=1.
  - Load latency is 2 cycles.
- Sub-word store:
  - Cycle N+1 in RD: read the old word.
  - Cycle N+2 in WR: ram_we_o=1 with the merged word on ram_wdata_o; the RAM commits at the end of N+2.
  - Cycle N+3 in RESP.
- Word store: skips RD. WR is in N+1 with ram_wdata_o = wdata, and RESP is in N+2.
- Lane merge:
  - Byte lane = addr[1:0]; replace bits [8*lane+7:8*lane] with wdata[7:0].
  - Half lane = addr[1]; replace bits [16*addr[1]+15:16*addr[1]] with wdata[15:0].
- Load extract uses the same lanes. Sign extension comes from the top bit of the extracted field unless req_unsigned_i=1.
- RESP always returns to IDLE on the next edge.
- rsp_valid_o is high for exactly one cycle per accepted request. There is no response back-pressure.
- rsp_rdata_o and rsp_err_o hold their last value outside RESP. Only rsp_valid_o qualifies them.
- ram_we_o is high only in WR. ram_addr_o holds the latched aligned address in RD and WR, and is 0 in IDLE and RESP.
- Back-to-back: a new request can be accepted in the cycle after RESP. Minimum spacing is therefore 3 cycles for a load and 4 cycles for a sub-word store.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10, then load word @0x10 -> ram_we_o high exactly 1 cycle (N+1). Load rsp_valid at N+2 returns 0xDEADBEEF, err=0.
- Byte read-modify-write: RAM word @0x20 preloaded with 0x11223344. Store byte 0xAB @0x22 -> WR writes 0x11AB3344. Signed byte load @0x22 -> 0xFFFFFFAB. Unsigned -> 0x000000AB.
- Half-word: store half 0x8001 @0x06 over 0x00000000 -> word 0x80010000. Signed half load @0x06 -> 0xFFFF8001. Unsigned -> 0x00008001.
- Misaligned and illegal: word load @0x13, half store @0x05, and size 11 -> rsp_valid at N+1, err=1, rdata=0. ram_we_o never asserts and the RAM contents are unchanged.
- Handshake: hold req_valid_i high with 3 queued requests -> req_ready_o low outside IDLE. Exactly 3 rsp_valid pulses, in order.
- Reset mid-store: assert rst_i while in WR -> ram_we_o drops immediately, the target word is unchanged, and there is no rsp_valid. After release, req_ready_o=1 and a normal load succeeds.
